ctrl_pipe: RTL and testbench

Carries the decoder's packed control bundles (EX/MEM/WB) and instruction register fields from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers. It unpacks each bundle at the stage that consumes it and inserts bubbles on flush and load-use hazards. It also generates the load-use stall and the EX-stage operand forwarding selects. The block is the receiving end of the main control decoder; its outputs feed the ALU, the data memory and the register-file write port.

---
 rtl/ctrl_pkg.sv | 70 +++++++
 rtl/ctrl_pipe_fwd_unit.sv | 22 ++
 rtl/ctrl_pipe.sv | 112 +++++++++++
 tb/tb_ctrl_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: bundle bit positions,
// stage-register layouts, bubble constants and the forwarding encoding.
package ctrl_pkg;

  localparam int EX_W  = 4;
  localparam int MEM_W = 2;
  localparam int WB_W  = 2;
  localparam int REG_W = 5;

  // Bit positions inside the decoder bundles
  localparam int EX_ALUSRC   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_REGDST   = 0;
  localparam int MEM_READ    = 1;
  localparam int MEM_WRITE   = 0;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Operand source select for the ALU inputs
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [EX_W-1:0]  ex;
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic [MEM_W-1:0] mem;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] wreg;
  } exmem_t;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] wreg;
  } memwb_t;

  // A bubble is an all-zero stage: no control activity, register $0
  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  // Pick the newest producer of src; $0 is never forwarded.
  function automatic fwd_sel_t fwd_select(
    input logic [REG_W-1:0] src,
    input logic             exmem_rw,
    input logic [REG_W-1:0] exmem_wreg,
    input logic             memwb_rw,
    input logic [REG_W-1:0] memwb_wreg
  );
    fwd_sel_t sel;
    sel = FWD_RF;
    if (exmem_rw && (exmem_wreg != '0) && (exmem_wreg == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb_rw && (memwb_wreg != '0) && (memwb_wreg == src)) begin
      sel = FWD_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage forwarding unit: compares the ID/EX source registers against the
// EX/MEM and MEM/WB destinations. EX/MEM is newer, so it wins a tie.
module fwd_unit
  import ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             exmem_reg_write,
  input  logic [REG_W-1:0] exmem_wreg,
  input  logic             memwb_reg_write,
  input  logic [REG_W-1:0] memwb_wreg,
  output fwd_sel_t         fwd_a,
  output fwd_sel_t         fwd_b
);

  // Both operand selects from the same priority rule
  always_comb begin
    fwd_a = fwd_select(ex_rs, exmem_reg_write, exmem_wreg, memwb_reg_write, memwb_wreg);
    fwd_b = fwd_select(ex_rt, exmem_reg_write, exmem_wreg, memwb_reg_write, memwb_wreg);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoder bundles through ID/EX, EX/MEM and MEM/WB,
// unpacks each bundle where it is consumed, detects load-use hazards and
// inserts bubbles on stall or flush. Later stages always advance.
module ctrl_pipe
  import ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [EX_W-1:0]  ex_i,
  input  logic [MEM_W-1:0] mem_i,
  input  logic [WB_W-1:0]  wb_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_dst_o,
  output logic [REG_W-1:0] ex_rs_o,
  output logic [REG_W-1:0] ex_rt_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [REG_W-1:0] mem_wreg_o,
  output logic             wb_reg_write_o,
  output logic             wb_mem_to_reg_o,
  output logic [REG_W-1:0] wb_wreg_o
);

  idex_t            idex_q, idex_d;
  exmem_t           exmem_q, exmem_d;
  memwb_t           memwb_q, memwb_d;
  logic             hazard;
  logic [REG_W-1:0] ex_wreg;
  fwd_sel_t         fwd_a, fwd_b;

  // Load-use hazard: a load in EX whose target is either ID source (both
  // compared regardless of whether the instruction really reads rt)
  always_comb begin
    hazard = idex_q.mem[MEM_READ] && (idex_q.rt != '0) &&
             ((idex_q.rt == rs_i) || (idex_q.rt == rt_i));
  end

  // Next contents of each stage register; ID/EX takes a bubble on stall/flush
  always_comb begin
    idex_d  = IDEX_BUBBLE;
    exmem_d = EXMEM_BUBBLE;
    memwb_d = MEMWB_BUBBLE;
    ex_wreg = idex_q.ex[EX_REGDST] ? idex_q.rd : idex_q.rt;

    if (!(hazard || flush_i)) begin
      idex_d.ex  = ex_i;
      idex_d.mem = mem_i;
      idex_d.wb  = wb_i;
      idex_d.rs  = rs_i;
      idex_d.rt  = rt_i;
      idex_d.rd  = rd_i;
    end

    exmem_d.mem  = idex_q.mem;
    exmem_d.wb   = idex_q.wb;
    exmem_d.wreg = ex_wreg;

    memwb_d.wb   = exmem_q.wb;
    memwb_d.wreg = exmem_q.wreg;
  end

  // Stage registers; reset overrides stall and flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q  <= IDEX_BUBBLE;
      exmem_q <= EXMEM_BUBBLE;
      memwb_q <= MEMWB_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  fwd_unit u_fwd (
    .ex_rs           (idex_q.rs),
    .ex_rt           (idex_q.rt),
    .exmem_reg_write (exmem_q.wb[WB_REGWRITE]),
    .exmem_wreg      (exmem_q.wreg),
    .memwb_reg_write (memwb_q.wb[WB_REGWRITE]),
    .memwb_wreg      (memwb_q.wreg),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  // Unpack each bundle at the stage that consumes it
  always_comb begin
    stall_o         = hazard;
    alu_src_o       = idex_q.ex[EX_ALUSRC];
    alu_op_o        = idex_q.ex[EX_ALUOP_HI:EX_ALUOP_LO];
    reg_dst_o       = idex_q.ex[EX_REGDST];
    ex_rs_o         = idex_q.rs;
    ex_rt_o         = idex_q.rt;
    fwd_a_o         = fwd_a;
    fwd_b_o         = fwd_b;
    mem_read_o      = exmem_q.mem[MEM_READ];
    mem_write_o     = exmem_q.mem[MEM_WRITE];
    mem_wreg_o      = exmem_q.wreg;
    wb_reg_write_o  = memwb_q.wb[WB_REGWRITE];
    wb_mem_to_reg_o = memwb_q.wb[WB_MEMTOREG];
    wb_wreg_o       = memwb_q.wreg;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: reset/latency sequence with an expected-
// destination queue, then a table of per-cycle vectors (ID inputs plus the
// outputs expected in that same cycle before the capturing edge).
module tb_ctrl_pipe;

  // Decoder bundle shorthands
  localparam int EXR  = 4'b0101;  // R-type: ALUOp=10, RegDst=1
  localparam int EXLS = 4'b1000;  // load/store: ALUSrc=1
  localparam int MLW  = 2'b10;
  localparam int MSW  = 2'b01;
  localparam int WR   = 2'b10;
  localparam int WLW  = 2'b11;

  logic       clk, rst;
  logic [3:0] ex_i;
  logic [1:0] mem_i, wb_i;
  logic [4:0] rs_i, rt_i, rd_i;
  logic       flush_i;
  logic       stall_o, alu_src_o, reg_dst_o;
  logic [1:0] alu_op_o, fwd_a_o, fwd_b_o;
  logic [4:0] ex_rs_o, ex_rt_o, mem_wreg_o, wb_wreg_o;
  logic       mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  typedef struct packed {
    logic [3:0] ex;
    logic [1:0] mem;
    logic [1:0] wb;
    logic [4:0] rs, rt, rd;
    logic       fl;
    logic       s;
    logic [3:0] xex;
    logic [4:0] xrs, xrt;
    logic [1:0] fa, fb;
    logic [1:0] xmem;
    logic [4:0] xmw;
    logic [1:0] xwb;
    logic [4:0] xww;
  } vec_t;

  vec_t tbl[29];

  ctrl_pipe dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ex_i            (ex_i),
    .mem_i           (mem_i),
    .wb_i            (wb_i),
    .rs_i            (rs_i),
    .rt_i            (rt_i),
    .rd_i            (rd_i),
    .flush_i         (flush_i),
    .stall_o         (stall_o),
    .alu_src_o       (alu_src_o),
    .alu_op_o        (alu_op_o),
    .reg_dst_o       (reg_dst_o),
    .ex_rs_o         (ex_rs_o),
    .ex_rt_o         (ex_rt_o),
    .fwd_a_o         (fwd_a_o),
    .fwd_b_o         (fwd_b_o),
    .mem_read_o      (mem_read_o),
    .mem_write_o     (mem_write_o),
    .mem_wreg_o      (mem_wreg_o),
    .wb_reg_write_o  (wb_reg_write_o),
    .wb_mem_to_reg_o (wb_mem_to_reg_o),
    .wb_wreg_o       (wb_wreg_o)
  );

  // Clock: period 10, rising edges at 5, 15, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int ex, int mem, int wb, int rs, int rt, int rd, int fl,
                              int s, int xex, int xrs, int xrt, int fa, int fb,
                              int xmem, int xmw, int xwb, int xww);
    vec_t v;
    v.ex = 4'(ex);   v.mem = 2'(mem); v.wb = 2'(wb);
    v.rs = 5'(rs);   v.rt = 5'(rt);   v.rd = 5'(rd);  v.fl = 1'(fl);
    v.s = 1'(s);     v.xex = 4'(xex); v.xrs = 5'(xrs); v.xrt = 5'(xrt);
    v.fa = 2'(fa);   v.fb = 2'(fb);   v.xmem = 2'(xmem); v.xmw = 5'(xmw);
    v.xwb = 2'(xwb); v.xww = 5'(xww);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int ex, input int mem, input int wb,
                       input int rs, input int rt, input int rd, input int fl);
    ex_i = 4'(ex); mem_i = 2'(mem); wb_i = 2'(wb);
    rs_i = 5'(rs); rt_i = 5'(rt); rd_i = 5'(rd); flush_i = 1'(fl);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".stall"}, stall_o, 0);
    check({tag, ".ex"}, {alu_src_o, alu_op_o, reg_dst_o}, 0);
    check({tag, ".ex_rs"}, ex_rs_o, 0);
    check({tag, ".ex_rt"}, ex_rt_o, 0);
    check({tag, ".fwd"}, {fwd_a_o, fwd_b_o}, 0);
    check({tag, ".mem"}, {mem_read_o, mem_write_o, mem_wreg_o}, 0);
    check({tag, ".wb"}, {wb_reg_write_o, wb_mem_to_reg_o, wb_wreg_o}, 0);
  endtask

  initial begin
    // Reset held for two edges with a live R-type presented in ID
    rst = 1'b1;
    drive(EXR, 0, WR, 1, 2, 5, 0);
    @(posedge clk); #1;
    check_all_zero("reset1");
    @(posedge clk); #1;
    check_all_zero("reset2");

    // Release; first edge captures rd=5, then 6 and 7 follow
    @(negedge clk); rst = 1'b0;
    #1 check_all_zero("released");
    @(negedge clk); #1;
    check("lat.alu_op", alu_op_o, 2'b10);
    check("lat.reg_dst", reg_dst_o, 1);
    check("lat.ex_rs", ex_rs_o, 1);
    check("lat.ex_rt", ex_rt_o, 2);
    check("lat.mem_wreg0", mem_wreg_o, 0);
    check("lat.wb_rw0", wb_reg_write_o, 0);
    exp_q.push_back(5'd5);
    drive(EXR, 0, WR, 3, 4, 6, 0);
    @(negedge clk); #1;
    check("lat.mem_wreg", mem_wreg_o, 5);
    check("lat.wb_rw_pre", wb_reg_write_o, 0);
    exp_q.push_back(5'd6);
    drive(EXR, 0, WR, 8, 9, 7, 0);
    @(negedge clk); #1;
    exp_q.push_back(5'd7);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("lat.wb_rw", wb_reg_write_o, 1);
      check("lat.wb_wreg", wb_wreg_o, exp_q.pop_front());
      @(negedge clk); #1;
    end
    check("lat.wb_drain", wb_reg_write_o, 0);
    check("lat.queue_empty", exp_q.size(), 0);

    // Clean restart for the table
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    //                 ex    mem  wb   rs  rt  rd fl | s  xex   xrs xrt fa fb xmem xmw xwb xww
    // R-type flow, EX/MEM priority, then MEM/WB forward over an independent op
    tbl[0]  = mk(EXR,  0,   WR,  1,  2,  5, 0,  0, 0,    0,  0,  0, 0, 0,   0,  0,  0);
    tbl[1]  = mk(EXR,  0,   WR,  6,  7,  3, 0,  0, EXR,  1,  2,  0, 0, 0,   0,  0,  0);
    tbl[2]  = mk(EXR,  0,   WR,  9, 10,  3, 0,  0, EXR,  6,  7,  0, 0, 0,   5,  0,  0);
    tbl[3]  = mk(EXR,  0,   WR,  3, 12, 11, 0,  0, EXR,  9, 10,  0, 0, 0,   3,  WR, 5);
    tbl[4]  = mk(EXR,  0,   WR,  1,  2, 20, 0,  0, EXR,  3, 12,  2, 0, 0,   3,  WR, 3);
    tbl[5]  = mk(EXR,  0,   WR,  1,  2, 21, 0,  0, EXR,  1,  2,  0, 0, 0,  11,  WR, 3);
    tbl[6]  = mk(EXR,  0,   WR, 20, 20, 22, 0,  0, EXR,  1,  2,  0, 0, 0,  20,  WR, 11);
    tbl[7]  = mk(0,    0,   0,   0,  0,  0, 0,  0, EXR, 20, 20,  1, 1, 0,  21,  WR, 20);
    // Writer to $0 followed by readers of $0: never forwarded
    tbl[8]  = mk(EXR,  0,   WR,  1,  2,  0, 0,  0, 0,    0,  0,  0, 0, 0,  22,  WR, 21);
    tbl[9]  = mk(EXR,  0,   WR,  0,  0,  4, 0,  0, EXR,  1,  2,  0, 0, 0,   0,  WR, 22);
    tbl[10] = mk(0,    0,   0,   0,  0,  0, 0,  0, EXR,  0,  0,  0, 0, 0,   0,  0,  0);
    tbl[11] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   4,  WR, 0);
    // Load-use on $8: one stall, bubble in EX, then MEM/WB forward
    tbl[12] = mk(EXLS, MLW, WLW, 1,  8,  0, 0,  0, 0,    0,  0,  0, 0, 0,   0,  WR, 4);
    tbl[13] = mk(EXR,  0,   WR,  8,  2,  9, 0,  1, EXLS, 1,  8,  0, 0, 0,   0,  0,  0);
    tbl[14] = mk(EXR,  0,   WR,  8,  2,  9, 0,  0, 0,    0,  0,  0, 0, MLW, 8,  0,  0);
    tbl[15] = mk(0,    0,   0,   0,  0,  0, 0,  0, EXR,  8,  2,  1, 0, 0,   0,  WLW, 8);
    tbl[16] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   9,  0,  0);
    // Load to $0 then use of $0: no stall
    tbl[17] = mk(EXLS, MLW, WLW, 1,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   0,  WR, 9);
    tbl[18] = mk(EXR,  0,   WR,  0,  0,  5, 0,  0, EXLS, 1,  0,  0, 0, 0,   0,  0,  0);
    tbl[19] = mk(0,    0,   0,   0,  0,  0, 0,  0, EXR,  0,  0,  0, 0, MLW, 0,  0,  0);
    tbl[20] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   5,  WLW, 0);
    // Flushed store never reaches MEM
    tbl[21] = mk(EXLS, MSW, 0,   1,  2,  0, 1,  0, 0,    0,  0,  0, 0, 0,   0,  WR, 5);
    tbl[22] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   0,  0,  0);
    tbl[23] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   0,  0,  0);
    // Stall and flush together: stall stays 1, squashed add never writes back
    tbl[24] = mk(EXLS, MLW, WLW, 1,  7,  0, 0,  0, 0,    0,  0,  0, 0, 0,   0,  0,  0);
    tbl[25] = mk(EXR,  0,   WR,  7,  3,  9, 1,  1, EXLS, 1,  7,  0, 0, 0,   0,  0,  0);
    tbl[26] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, MLW, 7,  0,  0);
    tbl[27] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   0,  WLW, 7);
    tbl[28] = mk(0,    0,   0,   0,  0,  0, 0,  0, 0,    0,  0,  0, 0, 0,   0,  0,  0);

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      drive(tbl[i].ex, tbl[i].mem, tbl[i].wb, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].fl);
      #1;
      check($sformatf("row%0d.stall", i), stall_o, tbl[i].s);
      check($sformatf("row%0d.ex", i), {alu_src_o, alu_op_o, reg_dst_o}, tbl[i].xex);
      check($sformatf("row%0d.ex_rs", i), ex_rs_o, tbl[i].xrs);
      check($sformatf("row%0d.ex_rt", i), ex_rt_o, tbl[i].xrt);
      check($sformatf("row%0d.fwd_a", i), fwd_a_o, tbl[i].fa);
      check($sformatf("row%0d.fwd_b", i), fwd_b_o, tbl[i].fb);
      check($sformatf("row%0d.mem", i), {mem_read_o, mem_write_o}, tbl[i].xmem);
      check($sformatf("row%0d.mem_wreg", i), mem_wreg_o, tbl[i].xmw);
      check($sformatf("row%0d.wb", i), {wb_reg_write_o, wb_mem_to_reg_o}, tbl[i].xwb);
      check($sformatf("row%0d.wb_wreg", i), wb_wreg_o, tbl[i].xww);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
